// File: rtl/bit_reverse_reorder.sv
// Ping-pong frame buffer that reorders natural-order FFT samples into bit-reversed order,
// or passes a frame straight through when bypass is set on its first word.
module bit_reverse_reorder #(
  parameter int unsigned LOG2N  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bypass,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned N = 1 << LOG2N;

  logic [DATA_W-1:0] mem [2][N];

  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       mode_q, mode_d;

  logic             wr_en, rd_en;
  logic [LOG2N-1:0] rd_rev, rd_addr;

  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign out_last  = out_valid && (rd_idx_q == '1);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  always_comb begin
    rd_rev = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      rd_rev[i] = rd_idx_q[int'(LOG2N) - 1 - i];
    end
  end

  // Mode bit 1 means the bank holds a bypass frame read back in natural order.
  assign rd_addr  = mode_q[rb_q] ? rd_idx_q : rd_rev;
  assign out_data = mem[rb_q][rd_addr];

  always_comb begin
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    full_d   = full_q;
    mode_d   = mode_q;

    if (wr_en) begin
      if (wr_idx_q == '0) begin
        mode_d[wb_q] = bypass;
      end
      if (wr_idx_q == '1) begin
        wr_idx_d     = '0;
        wb_d         = ~wb_q;
        full_d[wb_q] = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    // Set and clear always target different banks, so both apply independently.
    if (rd_en) begin
      if (rd_idx_q == '1) begin
        rd_idx_d     = '0;
        rb_d         = ~rb_q;
        full_d[rb_q] = 1'b0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      full_q   <= '0;
      mode_q   <= '0;
    end else begin
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      full_q   <= full_d;
      mode_q   <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wb_q][wr_idx_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Scoreboard bench: a frame-level reference model queues expected output words,
// and a negedge monitor compares every output transfer against that queue.
module tb_bit_reverse_reorder;

  localparam int unsigned LOG2N  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N      = 1 << LOG2N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bypass = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;

  bit_reverse_reorder #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bypass    (bypass),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] cur[$];
  logic              cur_byp;
  logic [DATA_W-1:0] got[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  bit gap_track = 0;
  int last_out_cyc = -1;
  int gaps = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model and monitor: outputs are compared first, then accepted inputs are modelled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL underflow: got output %0h, expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
        end
        got.push_back(out_data);
        if (gap_track && last_out_cyc >= 0 && cyc != last_out_cyc + 1) gaps++;
        last_out_cyc = cyc;
      end
      if (!out_valid && out_last) chk("out_last_idle", {31'd0, out_last}, 32'd0);
      if (gap_track && in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        in_cnt++;
        if (cur.size() == 0) cur_byp = bypass;
        cur.push_back(in_data);
        if (cur.size() == N) begin
          for (int i = 0; i < int'(N); i++) begin
            exp_t e;
            e.d    = cur[cur_byp ? i : brev(i)];
            e.last = (i == int'(N) - 1);
            exp_q.push_back(e);
          end
          cur.delete();
        end
      end
    end
  end

  // Starts and ends #1 after a rising edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic byp);
    int t;
    in_data  = d;
    bypass   = byp;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 2000) begin
        checks++;
        $display("FAIL send_timeout: word %0h never accepted, expected acceptance", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        checks++;
        $display("FAIL %s_drain_timeout: %0d words left, expected 0", name, exp_q.size());
        break;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] ref8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  bit rand_done;

  initial begin
    tick(2);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_last", {31'd0, out_last}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Natural to bit-reversed, with first-output latency.
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      send(i, 1'b0);
      if (i == 6) chk("lat_before_last", {31'd0, out_valid}, 32'd0);
    end
    chk("lat_first_valid", {31'd0, out_valid}, 32'd1);
    wait_drain("t1");
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_order", got[i], ref8[i]);

    // Back-to-back frames without bubbles.
    gaps = 0; stalls = 0; last_out_cyc = -1; gap_track = 1;
    for (int i = 0; i < 24; i++) send(i, 1'b0);
    wait_drain("t2");
    gap_track = 0;
    chk("t2_out_gaps", gaps, 0);
    chk("t2_in_stalls", stalls, 0);

    // Backpressure: both banks fill, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h100 + i, 1'b0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    tick(5);
    chk("bp_still_stalled", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    wait_drain("bp");

    // Bypass latched per frame; mid-frame toggles ignored.
    got.delete();
    for (int i = 0; i < 8; i++) send(32'h200 + i, (i < 4) ? 1'b1 : 1'b0);
    for (int i = 0; i < 8; i++) send(32'h300 + i, (i < 4) ? 1'b0 : 1'b1);
    wait_drain("byp");
    chk("byp_count", got.size(), 16);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("byp_a_natural", got[i], 32'h200 + i);
    for (int i = 0; i < 8 && 8 + i < got.size(); i++)
      chk("byp_b_reversed", got[8 + i], 32'h300 + ref8[i]);

    // Reset with one stored frame and a partial one.
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send(32'h400 + i, 1'b0);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) send(i, 1'b0);
    wait_drain("rst");
    chk("rst_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("rst_order", got[i], ref8[i]);

    // Random stalls on both sides over 1000 frames.
    in_cnt = 0; out_cnt = 0; rand_done = 0;
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          for (int i = 0; i < int'(N); i++) begin
            while ($urandom_range(0, 3) == 0) tick(1);
            send($urandom, 1'($urandom_range(0, 1)));
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("rand");
    chk("rand_in_count", in_cnt, 8000);
    chk("rand_out_count", out_cnt, 8000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
